// File: rtl/debug_bus_bridge_pkg.sv
// Shared constants and types for the UART debug bus bridge.
// Contents: command opcodes, response codes, parser FSM state enum and a helper that
// reports whether a parser state owns the CPU bus.
package debug_bus_bridge_pkg;

    localparam logic [7:0] OpHalt  = 8'h48;  // 'H'
    localparam logic [7:0] OpGo    = 8'h47;  // 'G'
    localparam logic [7:0] OpWrite = 8'h57;  // 'W'
    localparam logic [7:0] OpRead  = 8'h52;  // 'R'

    localparam logic [7:0] RespAck = 8'h06;
    localparam logic [7:0] RespNak = 8'h15;

    typedef enum logic [3:0] {
        StIdle,
        StAddrHi,
        StAddrLo,
        StData,
        StBusSetup,
        StStrobe,
        StHold,
        StRdWait,
        StRespond
    } state_e;

    // States in which the bridge drives address/data/write-enable.
    function automatic logic drives_bus(state_e s);
        return (s == StBusSetup) || (s == StStrobe) || (s == StHold) || (s == StRdWait);
    endfunction

endpackage

// File: rtl/debug_bus_bridge_m_uart_rx.sv
// uart_rx_m: 8N1 UART receiver, LSB first, idle high.
// Ports:
//   cpu_clk  - clock
//   rst      - asynchronous active-high reset
//   uart_rx  - serial input, asynchronous to cpu_clk
//   rx_valid - one-cycle pulse per byte received with a good stop bit
//   rx_byte  - received byte, valid while rx_valid is high (held afterwards)
module uart_rx_m #(
    parameter int unsigned CLKS_PER_BIT = 35
) (
    input  logic       cpu_clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte
);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    localparam int unsigned HalfBit = CLKS_PER_BIT / 2;

    rx_state_e   state_q, state_d;
    logic [1:0]  sync_q, sync_d;
    logic        prev_q, prev_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        valid_q, valid_d;
    logic        line;

    assign line     = sync_q[1];
    assign rx_valid = valid_q;
    assign rx_byte  = shift_q;

    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[0], uart_rx};
        prev_d  = line;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        unique case (state_q)
            RxIdle: begin
                if (prev_q && !line) begin
                    state_d = RxStart;
                    cnt_d   = '0;
                end
            end
            RxStart: begin
                if (32'(cnt_q) == HalfBit - 1) begin
                    // Line back high at mid start bit: treat as a glitch.
                    if (line) begin
                        state_d = RxIdle;
                    end else begin
                        state_d = RxData;
                        cnt_d   = '0;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RxData: begin
                if (32'(cnt_q) == CLKS_PER_BIT - 1) begin
                    shift_d = {line, shift_q[7:1]};
                    cnt_d   = '0;
                    if (bit_q == 3'd7) begin
                        state_d = RxStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RxStop: begin
                if (32'(cnt_q) == CLKS_PER_BIT - 1) begin
                    state_d = RxIdle;
                    valid_d = line;  // framing error drops the byte silently
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state_q <= RxIdle;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/debug_bus_bridge_m.sv
// debug_bus_bridge_m: UART-driven bring-up bus master for the 6502 CPU bus.
// Halts the CPU on request and performs single-byte reads/writes with CPU bus timing.
// Ports:
//   cpu_clk, rst        - clock, asynchronous active-high reset
//   uart_rx / uart_tx   - 8N1 serial command input / response output
//   cpu_halt            - holds the 6502 off the bus
//   bus_drive           - tristate enable for address/data/write-enable
//   bus_address         - bus address
//   bus_data_out        - write data
//   bus_data_in         - read data
//   bus_write_enable_B  - active-low write strobe
//   busy                - parser not idle
//   overrun             - sticky: a byte arrived while it could not be accepted
module debug_bus_bridge_m
    import debug_bus_bridge_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT     = 35,
    parameter int unsigned READ_WAIT_CYCLES = 2,
    parameter int unsigned TIMEOUT_CYCLES   = 65535
) (
    input  logic        cpu_clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        cpu_halt,
    output logic        bus_drive,
    output logic [15:0] bus_address,
    output logic [7:0]  bus_data_out,
    input  logic [7:0]  bus_data_in,
    output logic        bus_write_enable_B,
    output logic        busy,
    output logic        overrun
);

    logic       rx_valid;
    logic [7:0] rx_byte;

    uart_rx_m #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .cpu_clk (cpu_clk),
        .rst     (rst),
        .uart_rx (uart_rx),
        .rx_valid(rx_valid),
        .rx_byte (rx_byte)
    );

    // TX shifter: the frame shifts out LSB first and refills with ones, so an idle
    // shifter holds the line high.
    logic [9:0]  tx_shift_q, tx_shift_d;
    logic [3:0]  tx_bits_q, tx_bits_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic        tx_busy, tx_load;

    assign tx_busy = (tx_bits_q != 4'd0);
    assign uart_tx = tx_shift_q[0];

    // Parser, bus sequencer and timeout state.
    state_e      state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [7:0]  addr_hi_q, addr_hi_d;
    logic [7:0]  addr_lo_q, addr_lo_d;
    logic [7:0]  resp_q, resp_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] timeout_q, timeout_d;
    logic [15:0] bus_address_q, bus_address_d;
    logic [7:0]  bus_data_out_q, bus_data_out_d;
    logic        cpu_halt_q, cpu_halt_d;
    logic        bus_drive_q, bus_drive_d;
    logic        we_b_q, we_b_d;
    logic        busy_q, busy_d;
    logic        overrun_q, overrun_d;
    logic        timed_out;

    assign timed_out = (32'(timeout_q) >= TIMEOUT_CYCLES);

    always_comb begin
        state_d        = state_q;
        opcode_d       = opcode_q;
        addr_hi_d      = addr_hi_q;
        addr_lo_d      = addr_lo_q;
        resp_d         = resp_q;
        wait_cnt_d     = wait_cnt_q;
        bus_address_d  = bus_address_q;
        bus_data_out_d = bus_data_out_q;
        cpu_halt_d     = cpu_halt_q;
        overrun_d      = overrun_q;
        tx_load        = 1'b0;

        if (rx_valid) begin
            timeout_d = '0;
        end else if (timeout_q != 16'hFFFF) begin
            timeout_d = timeout_q + 16'd1;
        end else begin
            timeout_d = timeout_q;
        end

        case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    opcode_d = rx_byte;
                    case (rx_byte)
                        OpHalt: begin
                            cpu_halt_d = 1'b1;
                            resp_d     = RespAck;
                            state_d    = StRespond;
                        end
                        OpGo: begin
                            cpu_halt_d = 1'b0;
                            resp_d     = RespAck;
                            state_d    = StRespond;
                        end
                        OpWrite, OpRead: state_d = StAddrHi;
                        default: begin
                            resp_d  = RespNak;
                            state_d = StRespond;
                        end
                    endcase
                end
            end
            StAddrHi: begin
                if (rx_valid) begin
                    addr_hi_d = rx_byte;
                    state_d   = StAddrLo;
                end else if (timed_out) begin
                    state_d = StIdle;
                end
            end
            StAddrLo: begin
                if (rx_valid) begin
                    addr_lo_d = rx_byte;
                    if (opcode_q == OpWrite) begin
                        state_d = StData;
                    end else if (cpu_halt_q) begin
                        bus_address_d = {addr_hi_q, rx_byte};
                        state_d       = StBusSetup;
                    end else begin
                        resp_d  = RespNak;
                        state_d = StRespond;
                    end
                end else if (timed_out) begin
                    state_d = StIdle;
                end
            end
            StData: begin
                if (rx_valid) begin
                    if (cpu_halt_q) begin
                        bus_address_d  = {addr_hi_q, addr_lo_q};
                        bus_data_out_d = rx_byte;
                        state_d        = StBusSetup;
                    end else begin
                        resp_d  = RespNak;
                        state_d = StRespond;
                    end
                end else if (timed_out) begin
                    state_d = StIdle;
                end
            end
            StBusSetup: begin
                wait_cnt_d = '0;
                state_d    = (opcode_q == OpWrite) ? StStrobe : StRdWait;
            end
            StStrobe: state_d = StHold;
            StHold: begin
                resp_d  = RespAck;
                state_d = StRespond;
            end
            StRdWait: begin
                if (32'(wait_cnt_q) == READ_WAIT_CYCLES - 1) begin
                    resp_d  = bus_data_in;
                    state_d = StRespond;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            StRespond: begin
                if (!tx_busy) begin
                    tx_load = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Bytes landing while the bus cycle or response is in flight are dropped.
        if (rx_valid && (drives_bus(state_q) || state_q == StRespond)) begin
            overrun_d = 1'b1;
        end

        // Outputs are registered from the next state so they line up with state_q.
        bus_drive_d = drives_bus(state_d);
        we_b_d      = (state_d != StStrobe);
        busy_d      = (state_d != StIdle);
    end

    always_comb begin
        tx_shift_d = tx_shift_q;
        tx_bits_d  = tx_bits_q;
        tx_cnt_d   = tx_cnt_q;
        if (tx_load) begin
            tx_shift_d = {1'b1, resp_q, 1'b0};
            tx_bits_d  = 4'd10;
            tx_cnt_d   = '0;
        end else if (tx_busy) begin
            if (32'(tx_cnt_q) == CLKS_PER_BIT - 1) begin
                tx_shift_d = {1'b1, tx_shift_q[9:1]};
                tx_bits_d  = tx_bits_q - 4'd1;
                tx_cnt_d   = '0;
            end else begin
                tx_cnt_d = tx_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            opcode_q       <= '0;
            addr_hi_q      <= '0;
            addr_lo_q      <= '0;
            resp_q         <= '0;
            wait_cnt_q     <= '0;
            timeout_q      <= '0;
            bus_address_q  <= '0;
            bus_data_out_q <= '0;
            cpu_halt_q     <= 1'b0;
            bus_drive_q    <= 1'b0;
            we_b_q         <= 1'b1;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
            tx_shift_q     <= '1;
            tx_bits_q      <= '0;
            tx_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            opcode_q       <= opcode_d;
            addr_hi_q      <= addr_hi_d;
            addr_lo_q      <= addr_lo_d;
            resp_q         <= resp_d;
            wait_cnt_q     <= wait_cnt_d;
            timeout_q      <= timeout_d;
            bus_address_q  <= bus_address_d;
            bus_data_out_q <= bus_data_out_d;
            cpu_halt_q     <= cpu_halt_d;
            bus_drive_q    <= bus_drive_d;
            we_b_q         <= we_b_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
            tx_shift_q     <= tx_shift_d;
            tx_bits_q      <= tx_bits_d;
            tx_cnt_q       <= tx_cnt_d;
        end
    end

    assign cpu_halt           = cpu_halt_q;
    assign bus_drive          = bus_drive_q;
    assign bus_address        = bus_address_q;
    assign bus_data_out       = bus_data_out_q;
    assign bus_write_enable_B = we_b_q;
    assign busy               = busy_q;
    assign overrun            = overrun_q;

endmodule
